// File: rtl/fifo_level_pkg.sv
// fifo_level_pkg
//  Shared definitions for the fifo_level buffer: width helpers used to size the
//  level and pointer buses, the sticky error-flag record and its update rule.
package fifo_level_pkg;

  // Ceiling log2 with a floor of 1 so a bus never collapses to zero bits.
  function automatic int unsigned fifo_clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    if (w == 0) w = 1;
    return w;
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

  // Sticky flag update: a new event in the same cycle beats a clear request.
  function automatic logic sticky_next(input logic cur, input logic clr, input logic evt);
    return evt | (cur & ~clr);
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// fifo_wrap_ptr
//  Modulo-DEPTH address pointer. Wraps from DEPTH-1 back to 0 by explicit
//  compare, so DEPTH need not be a power of two.
//  Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous active-high reset, ptr -> 0
//   clr    in   synchronous clear, ptr -> 0 (beats inc)
//   inc    in   advance by one with wrap
//   ptr    out  current pointer value, AW bits
module fifo_wrap_ptr
  import fifo_level_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = fifo_clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      ptr <= '0;
    end else if (inc) begin
      if (ptr == AW'(DEPTH - 1)) ptr <= '0;
      else                       ptr <= ptr + AW'(1);
    end
  end

endmodule

// File: rtl/fifo_level.sv
// fifo_level
//  Single-clock first-word-fall-through FIFO with fill-level reporting,
//  almost-full/almost-empty thresholds, synchronous flush and sticky
//  overflow/underflow flags. All status outputs are registered from the
//  next-state level, so no input strobe reaches a flag combinationally.
//  Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   flush                   empty the FIFO next edge, memory untouched
//   in_shift, in_data       write strobe and word
//   in_full, in_afull       level == DEPTH, level >= AFULL
//   out_pop, out_data       read strobe, head word (0 while empty)
//   out_nempty, out_aempty  level != 0, level <= AEMPTY
//   level                   occupancy 0..DEPTH
//   overflow, underflow     sticky error flags
//   clear_err               clear sticky flags
module fifo_level
  import fifo_level_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int AFULL  = DEPTH - 2,
  parameter int AEMPTY = 2,
  parameter int LW     = fifo_clog2(DEPTH + 1),
  parameter int AW     = fifo_clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_shift,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_full,
  output logic             in_afull,
  input  logic             out_pop,
  output logic [WIDTH-1:0] out_data,
  output logic             out_nempty,
  output logic             out_aempty,
  output logic [LW-1:0]    level,
  output logic             overflow,
  output logic             underflow,
  input  logic             clear_err
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic             wr_en;
  logic [LW-1:0]    level_nxt;
  err_flags_t       err_evt;

  // Accept decisions use the registered flags only; flush suppresses both
  // the transfers and the error events they would otherwise raise.
  always_comb begin
    push              = in_shift & ~in_full & ~flush;
    pop               = out_pop & out_nempty & ~flush;
    wr_en             = push & ~reset;
    err_evt.overflow  = in_shift & in_full & ~flush;
    err_evt.underflow = out_pop & ~out_nempty & ~flush;
    level_nxt         = level;
    if (flush)             level_nxt = '0;
    else if (push && !pop) level_nxt = level + LW'(1);
    else if (pop && !push) level_nxt = level - LW'(1);
  end

  fifo_wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wr_ptr (
    .clock (clock),
    .reset (reset),
    .clr   (flush),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rd_ptr (
    .clock (clock),
    .reset (reset),
    .clr   (flush),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  // Storage: write-only-on-push, no reset, so it maps onto distributed RAM.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  // Level, thresholds and sticky flags all registered from the next level.
  always_ff @(posedge clock) begin
    if (reset) begin
      level      <= '0;
      in_full    <= 1'b0;
      in_afull   <= 1'b0;
      out_nempty <= 1'b0;
      out_aempty <= 1'b1;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      level      <= level_nxt;
      in_full    <= (level_nxt == LW'(DEPTH));
      in_afull   <= (level_nxt >= LW'(AFULL));
      out_nempty <= (level_nxt != '0);
      out_aempty <= (level_nxt <= LW'(AEMPTY));
      overflow   <= sticky_next(overflow, clear_err, err_evt.overflow);
      underflow  <= sticky_next(underflow, clear_err, err_evt.underflow);
    end
  end

  // First-word fall-through: the head word is visible without a read strobe.
  assign out_data = out_nempty ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fifo_level.sv
// tb_fifo_level
//  Directed bench for fifo_level: a DEPTH=16 instance for the main behaviour
//  and a DEPTH=5 instance for non-power-of-two pointer wrap.
module tb_fifo_level;

  logic clock;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // DEPTH=16 instance
  logic       rst, fl, sh, pp, ce;
  logic [7:0] din;
  logic       full, afull, nempty, aempty, ovf, unf;
  logic [7:0] dout;
  logic [4:0] lvl;

  fifo_level #(.WIDTH(8), .DEPTH(16)) dut16 (
    .clock(clock), .reset(rst), .flush(fl), .in_shift(sh), .in_data(din),
    .in_full(full), .in_afull(afull), .out_pop(pp), .out_data(dout),
    .out_nempty(nempty), .out_aempty(aempty), .level(lvl),
    .overflow(ovf), .underflow(unf), .clear_err(ce)
  );

  // DEPTH=5 instance
  logic       rst5, sh5, pp5;
  logic [7:0] din5;
  logic       full5, afull5, nempty5, aempty5, ovf5, unf5;
  logic [7:0] dout5;
  logic [2:0] lvl5;

  fifo_level #(.WIDTH(8), .DEPTH(5)) dut5 (
    .clock(clock), .reset(rst5), .flush(1'b0), .in_shift(sh5), .in_data(din5),
    .in_full(full5), .in_afull(afull5), .out_pop(pp5), .out_data(dout5),
    .out_nempty(nempty5), .out_aempty(aempty5), .level(lvl5),
    .overflow(ovf5), .underflow(unf5), .clear_err(1'b0)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: inputs were set before this call, outputs sampled at negedge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle16();
    fl = 0; sh = 0; pp = 0; ce = 0; din = 8'h00;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_level"},  32'(lvl),    32'd0);
    check({tag, "_nempty"}, 32'(nempty), 32'd0);
    check({tag, "_aempty"}, 32'(aempty), 32'd1);
    check({tag, "_data"},   32'(dout),   32'd0);
    check({tag, "_full"},   32'(full),   32'd0);
    check({tag, "_afull"},  32'(afull),  32'd0);
    check({tag, "_ovf"},    32'(ovf),    32'd0);
    check({tag, "_unf"},    32'(unf),    32'd0);
  endtask

  initial begin
    idle16();
    rst = 1; rst5 = 1; sh5 = 0; pp5 = 0; din5 = 8'h00;
    @(negedge clock);
    step();
    rst = 0; rst5 = 0;
    step();

    // 1: reset then idle
    check_reset_state("rst_idle");

    // 2: fill 0x01..0x10, thresholds per level
    for (int i = 1; i <= 16; i++) begin
      sh = 1; din = 8'(i);
      step();
      check($sformatf("fill_lvl%0d", i),   32'(lvl),    32'(i));
      check($sformatf("fill_afull%0d", i), 32'(afull),  32'(i >= 14));
      check($sformatf("fill_full%0d", i),  32'(full),   32'(i == 16));
      check($sformatf("fill_aempt%0d", i), 32'(aempty), 32'(i <= 2));
      check($sformatf("fill_head%0d", i),  32'(dout),   32'h01);
    end
    din = 8'h11;                       // 17th push, must be dropped
    step();
    sh = 0;
    check("ovf_set",   32'(ovf),  32'd1);
    check("ovf_level", 32'(lvl),  32'd16);
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("drain_%0d", i), 32'(dout), 32'(i));
      pp = 1;
      step();
    end
    pp = 0;
    check("drain_level",  32'(lvl),    32'd0);
    check("drain_nempty", 32'(nempty), 32'd0);
    check("drain_data",   32'(dout),   32'd0);
    check("drain_ovf",    32'(ovf),    32'd1);
    ce = 1;
    step();
    ce = 0;
    check("clr_ovf", 32'(ovf), 32'd0);

    // 4: level 8, simultaneous push 0xAA and pop
    for (int i = 1; i <= 8; i++) begin
      sh = 1; din = 8'(8'h20 + i);
      step();
    end
    check("l8_level", 32'(lvl),  32'd8);
    check("l8_head",  32'(dout), 32'h21);
    sh = 1; din = 8'hAA; pp = 1;
    step();
    sh = 0;
    check("pp_level", 32'(lvl), 32'd8);
    for (int i = 2; i <= 8; i++) begin
      check($sformatf("pp_head%0d", i), 32'(dout), 32'(8'h20 + i));
      step();
    end
    pp = 0;
    check("pp_aa",     32'(dout), 32'hAA);
    check("pp_aa_lvl", 32'(lvl),  32'd1);
    pp = 1;
    step();
    pp = 0;
    check("pp_empty", 32'(lvl), 32'd0);

    // 5: pop+push on empty
    pp = 1; sh = 1; din = 8'h55;
    step();
    sh = 0;
    check("unf_set",   32'(unf),  32'd1);
    check("unf_data",  32'(dout), 32'h55);
    check("unf_level", 32'(lvl),  32'd1);
    step();                            // pops 0x55 (valid pop)
    check("unf_hold",  32'(unf),  32'd1);
    ce = 1;                            // pop on empty again with clear
    step();
    check("unf_win",   32'(unf),  32'd1);
    pp = 0;
    step();
    ce = 0;
    check("unf_clr",   32'(unf),  32'd0);

    // 6: flush at level 6 with sticky overflow set
    for (int i = 0; i < 17; i++) begin
      sh = 1; din = 8'(8'h60 + i);
      step();
    end
    sh = 0;
    check("f_ovf", 32'(ovf), 32'd1);
    fl = 1;
    step();
    fl = 0;
    for (int i = 0; i < 6; i++) begin
      sh = 1; din = 8'(8'h70 + i);
      step();
    end
    check("f_lvl6", 32'(lvl), 32'd6);
    fl = 1; sh = 1; din = 8'hEE;
    step();
    check("f_level",  32'(lvl),    32'd0);
    check("f_nempty", 32'(nempty), 32'd0);
    check("f_ovf_kp", 32'(ovf),    32'd1);
    sh = 0; pp = 1;                    // flush with pop on empty: no underflow
    step();
    fl = 0;
    check("f_no_unf", 32'(unf), 32'd0);
    step();                            // pop on empty without flush
    pp = 0;
    check("f_unf", 32'(unf), 32'd1);
    sh = 1; din = 8'h77;
    step();
    check("f_push_data", 32'(dout), 32'h77);
    din = 8'h78;
    step();
    din = 8'h79; rst = 1; pp = 1;      // reset mid-burst
    step();
    rst = 0;
    idle16();
    check_reset_state("rst_mid");

    // 3: DEPTH=5, three words ahead, then 12 push/pop pairs
    for (int k = 0; k < 3; k++) begin
      sh5 = 1; din5 = 8'(8'h40 + k);
      step();
    end
    check("d5_lvl3", 32'(lvl5), 32'd3);
    for (int j = 0; j < 12; j++) begin
      check($sformatf("d5_head%0d", j), 32'(dout5), 32'(8'h40 + j));
      sh5 = 1; pp5 = 1; din5 = 8'(8'h43 + j);
      step();
      check($sformatf("d5_lvl%0d", j), 32'(lvl5), 32'd3);
    end
    sh5 = 0;
    for (int j = 12; j < 15; j++) begin
      check($sformatf("d5_tail%0d", j), 32'(dout5), 32'(8'h40 + j));
      pp5 = 1;
      step();
    end
    pp5 = 0;
    check("d5_empty", 32'(nempty5), 32'd0);
    check("d5_unf",   32'(unf5),    32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
